lsu_arbiter: RTL and testbench

//  Two-master arbiter/sequencer in front of the shared lsu (data_mem + MMIO I/O).
//  M0 = core pipeline memory stage, M1 = debug/boot loader. Grants one access per cycle.

---
 rtl/lsu_arb_pkg.sv | 39 +++
 rtl/lsu_arbiter_rr_arb2.sv | 38 +++
 rtl/lsu_arbiter.sv | 170 +++++++++++++++++
 tb/tb_lsu_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared encodings, command record and alignment rule for the two-master lsu arbiter.
package lsu_arb_pkg;

    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE   = 1'b0;
    localparam state_t ST_ACCESS = 1'b1;

    typedef struct packed {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] st_data;
        logic [1:0]  s_length;
        logic [2:0]  l_length;
        logic        l_unsigned;
        logic        id;
        logic        misaligned;
    } cmd_t;

    // Loads encode their size in l_length[1:0] with the same code as s_length.
    function automatic logic is_misaligned(input logic       wren,
                                           input logic [1:0] s_length,
                                           input logic [2:0] l_length,
                                           input logic [1:0] addr_lo);
        logic [1:0] size;
        logic       bad;
        size = wren ? s_length : l_length[1:0];
        bad  = 1'b0;
        if (size == LEN_WORD) begin
            bad = (addr_lo != 2'b00);
        end else if (size == LEN_HALF) begin
            bad = addr_lo[0];
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_arbiter_rr_arb2.sv
// Two-way round-robin picker; the pointer moves to the loser after every grant.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] req,
    input  logic       lock_m1,
    input  logic       force_m0,
    output logic [1:0] gnt
);

    logic ptr_q;

    always_comb begin
        gnt = 2'b00;
        if (i_rst) begin
            gnt = 2'b00;
        end else if (force_m0 && req[0]) begin
            gnt = 2'b01;
        end else if (lock_m1) begin
            gnt = {req[1], 1'b0};
        end else if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= 1'b0;
        end else if (gnt[0]) begin
            ptr_q <= 1'b1;
        end else if (gnt[1]) begin
            ptr_q <= 1'b0;
        end
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Core/debug arbiter in front of the lsu: one registered access per cycle, in-order responses.
// state     | meaning
// ST_IDLE   | no command held, lsu driven idle (all zero)
// ST_ACCESS | command register valid, lsu driven this cycle
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 256,
    parameter int CNT_W        = 9
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_req,
    input  logic        i_m0_wren,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_st_data,
    input  logic [1:0]  i_m0_s_length,
    input  logic [2:0]  i_m0_l_length,
    input  logic        i_m0_l_unsigned,
    input  logic        i_m1_req,
    input  logic        i_m1_wren,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_st_data,
    input  logic [1:0]  i_m1_s_length,
    input  logic [2:0]  i_m1_l_length,
    input  logic        i_m1_l_unsigned,
    input  logic        i_m1_lock,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_err,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_err,
    output logic [31:0] o_lsu_addr,
    output logic        o_lsu_wren,
    output logic [31:0] o_lsu_st_data,
    output logic [1:0]  o_lsu_s_length,
    output logic [2:0]  o_lsu_l_length,
    output logic        o_lsu_l_unsigned,
    input  logic [31:0] i_lsu_ld_data,
    output logic        o_lock_timeout
);

    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_TIMEOUT - 1);

    logic [1:0]       gnt;
    logic             lock_q, lock_eff, force_q, timeout_q, timeout_hit;
    logic [CNT_W-1:0] lock_cnt_q;
    state_t           state_q;
    cmd_t             cmd_q, cmd_d;
    logic             access;
    logic             rsp_valid_q, rsp_id_q, rsp_err_q;
    logic [31:0]      rsp_data_q;

    // A dropped i_m1_lock releases M0 in the same cycle, not one later.
    assign lock_eff = lock_q & i_m1_lock;

    rr_arb2 u_rr_arb2 (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .req      ({i_m1_req, i_m0_req}),
        .lock_m1  (lock_eff),
        .force_m0 (force_q),
        .gnt      (gnt)
    );

    assign o_m0_gnt = gnt[0];
    assign o_m1_gnt = gnt[1];

    always_comb begin
        cmd_d = '0;
        if (gnt[1]) begin
            cmd_d.wren       = i_m1_wren;
            cmd_d.addr       = i_m1_addr;
            cmd_d.st_data    = i_m1_st_data;
            cmd_d.s_length   = i_m1_s_length;
            cmd_d.l_length   = i_m1_l_length;
            cmd_d.l_unsigned = i_m1_l_unsigned;
            cmd_d.id         = 1'b1;
        end else begin
            cmd_d.wren       = i_m0_wren;
            cmd_d.addr       = i_m0_addr;
            cmd_d.st_data    = i_m0_st_data;
            cmd_d.s_length   = i_m0_s_length;
            cmd_d.l_length   = i_m0_l_length;
            cmd_d.l_unsigned = i_m0_l_unsigned;
            cmd_d.id         = 1'b0;
        end
        cmd_d.misaligned = is_misaligned(cmd_d.wren, cmd_d.s_length,
                                         cmd_d.l_length, cmd_d.addr[1:0]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
        end else begin
            state_q <= (|gnt) ? ST_ACCESS : ST_IDLE;
            if (|gnt) begin
                cmd_q <= cmd_d;
            end
        end
    end

    assign access           = (state_q == ST_ACCESS);
    assign o_lsu_addr       = access ? cmd_q.addr : 32'h0;
    assign o_lsu_wren       = access & cmd_q.wren & ~cmd_q.misaligned;
    assign o_lsu_st_data    = access ? cmd_q.st_data : 32'h0;
    assign o_lsu_s_length   = access ? cmd_q.s_length : 2'b00;
    assign o_lsu_l_length   = access ? cmd_q.l_length : 3'b000;
    assign o_lsu_l_unsigned = access & cmd_q.l_unsigned;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'h0;
        end else begin
            rsp_valid_q <= access;
            if (access) begin
                rsp_id_q   <= cmd_q.id;
                rsp_err_q  <= cmd_q.misaligned;
                rsp_data_q <= (cmd_q.wren | cmd_q.misaligned) ? 32'h0 : i_lsu_ld_data;
            end
        end
    end

    assign o_m0_rvalid = rsp_valid_q & ~rsp_id_q;
    assign o_m1_rvalid = rsp_valid_q & rsp_id_q;
    assign o_m0_err    = o_m0_rvalid & rsp_err_q;
    assign o_m1_err    = o_m1_rvalid & rsp_err_q;
    assign o_m0_rdata  = o_m0_rvalid ? rsp_data_q : 32'h0;
    assign o_m1_rdata  = o_m1_rvalid ? rsp_data_q : 32'h0;

    // Watchdog holds the number of locked M1 grants still allowed.
    assign timeout_hit = lock_eff ? (lock_cnt_q == CNT_W'(1)) : (LOCK_LOAD == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lock_q     <= 1'b0;
            lock_cnt_q <= '0;
            force_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (|gnt) begin
                force_q <= 1'b0;
            end
            if (gnt[1] && i_m1_lock) begin
                if (timeout_hit) begin
                    lock_q     <= 1'b0;
                    lock_cnt_q <= '0;
                    force_q    <= 1'b1;
                    timeout_q  <= 1'b1;
                end else begin
                    lock_q     <= 1'b1;
                    lock_cnt_q <= lock_eff ? (lock_cnt_q - CNT_W'(1)) : LOCK_LOAD;
                end
            end else if (gnt[1] || !i_m1_lock) begin
                lock_q     <= 1'b0;
                lock_cnt_q <= '0;
            end
        end
    end

    assign o_lock_timeout = timeout_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Randomized bench for lsu_arbiter against a grant/response scoreboard and a small lsu memory.
module tb_lsu_arbiter;

    localparam int LT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_wren, m0_l_unsigned;
    logic [31:0] m0_addr, m0_st_data;
    logic [1:0]  m0_s_length;
    logic [2:0]  m0_l_length;
    logic        m1_req, m1_wren, m1_l_unsigned, m1_lock;
    logic [31:0] m1_addr, m1_st_data;
    logic [1:0]  m1_s_length;
    logic [2:0]  m1_l_length;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] lsu_addr, lsu_st_data, lsu_ld_data;
    logic        lsu_wren, lsu_l_unsigned, lock_timeout;
    logic [1:0]  lsu_s_length;
    logic [2:0]  lsu_l_length;

    always #5 clk = ~clk;

    lsu_arbiter #(.LOCK_TIMEOUT(LT), .CNT_W(9)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_req(m0_req), .i_m0_wren(m0_wren), .i_m0_addr(m0_addr),
        .i_m0_st_data(m0_st_data), .i_m0_s_length(m0_s_length),
        .i_m0_l_length(m0_l_length), .i_m0_l_unsigned(m0_l_unsigned),
        .i_m1_req(m1_req), .i_m1_wren(m1_wren), .i_m1_addr(m1_addr),
        .i_m1_st_data(m1_st_data), .i_m1_s_length(m1_s_length),
        .i_m1_l_length(m1_l_length), .i_m1_l_unsigned(m1_l_unsigned),
        .i_m1_lock(m1_lock),
        .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata), .o_m0_err(m0_err),
        .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata), .o_m1_err(m1_err),
        .o_lsu_addr(lsu_addr), .o_lsu_wren(lsu_wren), .o_lsu_st_data(lsu_st_data),
        .o_lsu_s_length(lsu_s_length), .o_lsu_l_length(lsu_l_length),
        .o_lsu_l_unsigned(lsu_l_unsigned), .i_lsu_ld_data(lsu_ld_data),
        .o_lock_timeout(lock_timeout)
    );

    function automatic logic [31:0] mem_init_val(input int i);
        return (i == 1) ? 32'hDEADBEEF : (32'h8070_6050 ^ (32'(i) * 32'h1F3B_5D79));
    endfunction

    function automatic logic [31:0] ld_extract(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] len);
        logic [31:0] s;
        s = w >> (32'(off) * 8);
        case (len[1:0])
            2'b00:   return len[2] ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            2'b01:   return len[2] ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: return s;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [1:0] off,
                                             input logic [31:0] d, input logic [1:0] len);
        logic [31:0] m;
        case (len)
            2'b00:   m = 32'h0000_00FF;
            2'b01:   m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        m = m << (32'(off) * 8);
        return (w & ~m) | ((d << (32'(off) * 8)) & m);
    endfunction

    // lsu stand-in: combinational read, write at the end of the access cycle
    logic [31:0] lsu_mem [16];
    assign lsu_ld_data = ld_extract(lsu_mem[lsu_addr[5:2]], lsu_addr[1:0], lsu_l_length);
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) lsu_mem[i] <= mem_init_val(i);
        end else if (lsu_wren) begin
            lsu_mem[lsu_addr[5:2]] <= st_merge(lsu_mem[lsu_addr[5:2]], lsu_addr[1:0],
                                               lsu_st_data, lsu_s_length);
        end
    end

    typedef struct packed {
        int          due;
        bit          id;
        bit          err;
        logic [31:0] data;
    } rsp_t;

    int          n_tests, n_fail, cyc, last_gnt;
    int          fav, lock_run;
    bit          m1_locked, force_m0, to_seen;
    logic [31:0] ref_mem [16];
    rsp_t        exp_q [$];
    logic        exp_wren;
    logic [31:0] exp_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        fav = 0; lock_run = 0; m1_locked = 0; force_m0 = 0; to_seen = 0;
        exp_q.delete();
        exp_wren = 1'b0; exp_addr = 32'h0;
        for (int i = 0; i < 16; i++) ref_mem[i] = mem_init_val(i);
    endtask

    // Winner under the fairness/lock/watchdog rules; -1 means nobody is granted.
    function automatic int model_pick();
        if (rst) return -1;
        if (force_m0 && m0_req) return 0;
        if (m1_locked && m1_lock) return m1_req ? 1 : -1;
        if (m0_req && m1_req) return fav;
        if (m0_req) return 0;
        if (m1_req) return 1;
        return -1;
    endfunction

    task automatic step();
        int          g;
        rsp_t        e;
        bit          due, eff, mis, w;
        logic [31:0] a, d;
        logic [1:0]  sl, sz;
        logic [2:0]  ll;
        @(negedge clk);
        g = model_pick();
        check_eq("gnt0", 32'(m0_gnt), 32'(g == 0));
        check_eq("gnt1", 32'(m1_gnt), 32'(g == 1));
        check_eq("lsu_wren", 32'(lsu_wren), 32'(exp_wren));
        check_eq("lsu_addr", lsu_addr, exp_addr);
        due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        e = '0;
        if (due) e = exp_q.pop_front();
        check_eq("rvalid0", 32'(m0_rvalid), 32'(due && !e.id));
        check_eq("rvalid1", 32'(m1_rvalid), 32'(due && e.id));
        check_eq("rdata0", m0_rdata, (due && !e.id) ? e.data : 32'h0);
        check_eq("rdata1", m1_rdata, (due && e.id) ? e.data : 32'h0);
        check_eq("err0", 32'(m0_err), 32'(due && !e.id && e.err));
        check_eq("err1", 32'(m1_err), 32'(due && e.id && e.err));
        check_eq("lock_timeout", 32'(lock_timeout), 32'(to_seen));
        last_gnt = g;
        if (rst) begin
            model_reset();
        end else begin
            eff = m1_locked && m1_lock;
            exp_wren = 1'b0;
            exp_addr = 32'h0;
            if (g >= 0) begin
                w  = (g == 1) ? m1_wren : m0_wren;
                a  = (g == 1) ? m1_addr : m0_addr;
                d  = (g == 1) ? m1_st_data : m0_st_data;
                sl = (g == 1) ? m1_s_length : m0_s_length;
                ll = (g == 1) ? m1_l_length : m0_l_length;
                sz = w ? sl : ll[1:0];
                mis = (sz == 2'b10 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]);
                e.due  = cyc + 2;
                e.id   = (g == 1);
                e.err  = mis;
                e.data = (w || mis) ? 32'h0 : ld_extract(ref_mem[a[5:2]], a[1:0], ll);
                if (w && !mis) ref_mem[a[5:2]] = st_merge(ref_mem[a[5:2]], a[1:0], d, sl);
                exp_q.push_back(e);
                exp_wren = w && !mis;
                exp_addr = a;
                fav = 1 - g;
                force_m0 = 0;
                if (g == 1 && m1_lock) begin
                    lock_run = (eff ? lock_run : 0) + 1;
                    if (lock_run == LT) begin
                        m1_locked = 0; lock_run = 0; to_seen = 1; force_m0 = 1;
                    end else begin
                        m1_locked = 1;
                    end
                end else if (g == 1) begin
                    m1_locked = 0; lock_run = 0;
                end
            end
            if (!m1_lock) begin
                m1_locked = 0; lock_run = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_cmd(input int m, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] sl, input logic [2:0] ll);
        if (m == 0) begin
            m0_wren = w; m0_addr = a; m0_st_data = d; m0_s_length = sl;
            m0_l_length = ll; m0_l_unsigned = ll[2];
        end else begin
            m1_wren = w; m1_addr = a; m1_st_data = d; m1_s_length = sl;
            m1_l_length = ll; m1_l_unsigned = ll[2];
        end
    endtask

    task automatic rand_cmd(input int m);
        logic [31:0] a;
        logic [2:0]  ll;
        a = 32'h2000 + 32'($urandom_range(0, 15)) * 4;
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(0, 3));
        case ($urandom_range(0, 4))
            0:       ll = 3'b000;
            1:       ll = 3'b001;
            2:       ll = 3'b010;
            3:       ll = 3'b100;
            default: ll = 3'b101;
        endcase
        set_cmd(m, 1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 2)), ll);
    endtask

    int n1;
    bit got0;

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; last_gnt = -1;
        rst = 1'b1; m1_req = 1'b0; m1_lock = 1'b0;
        set_cmd(0, 1'b0, 32'h2004, 32'h0, 2'b00, 3'b010);
        set_cmd(1, 1'b0, 32'h2008, 32'h0, 2'b00, 3'b010);
        m0_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_eq("rst_gnt0", 32'(m0_gnt), 32'h0);
        check_eq("rst_rvalid0", 32'(m0_rvalid), 32'h0);
        check_eq("rst_rvalid1", 32'(m1_rvalid), 32'h0);
        check_eq("rst_rdata0", m0_rdata, 32'h0);
        check_eq("rst_lsu_wren", 32'(lsu_wren), 32'h0);
        check_eq("rst_lsu_addr", lsu_addr, 32'h0);
        check_eq("rst_lock_to", 32'(lock_timeout), 32'h0);
        m0_req = 1'b0;
        step();
        rst = 1'b0;

        // both masters loading: alternate starting with M0
        set_cmd(0, 1'b0, 32'h2008, 32'h0, 2'b00, 3'b010);
        set_cmd(1, 1'b0, 32'h200C, 32'h0, 2'b00, 3'b010);
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("rr_gnt0", 32'(m0_gnt), 32'(i % 2 == 0));
            check_eq("rr_gnt1", 32'(m1_gnt), 32'(i % 2 == 1));
            step();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) step();

        // lw 0x2004 alone
        set_cmd(0, 1'b0, 32'h2004, 32'h0, 2'b00, 3'b010);
        m0_req = 1'b1;
        #1 check_eq("lw_gnt0", 32'(m0_gnt), 32'h1);
        step();
        m0_req = 1'b0;
        step();
        #1;
        check_eq("lw_rvalid0", 32'(m0_rvalid), 32'h1);
        check_eq("lw_rdata0", m0_rdata, 32'hDEADBEEF);
        step();

        // misaligned sw 0x2002 is suppressed and flagged
        set_cmd(0, 1'b1, 32'h2002, 32'hA5A5_A5A5, 2'b10, 3'b000);
        m0_req = 1'b1;
        #1 check_eq("mis_gnt0", 32'(m0_gnt), 32'h1);
        step();
        m0_req = 1'b0;
        #1 check_eq("mis_lsu_wren", 32'(lsu_wren), 32'h0);
        step();
        #1;
        check_eq("mis_rvalid0", 32'(m0_rvalid), 32'h1);
        check_eq("mis_err0", 32'(m0_err), 32'h1);
        check_eq("mis_rdata0", m0_rdata, 32'h0);
        set_cmd(0, 1'b0, 32'h2000, 32'h0, 2'b00, 3'b010);
        m0_req = 1'b1;
        step();
        m0_req = 1'b0;
        step();
        #1 check_eq("mis_mem_kept", m0_rdata, mem_init_val(0));
        step();

        // sb from M1 then lbu from M0, back-to-back
        set_cmd(1, 1'b1, 32'h7000, 32'h0000_0055, 2'b00, 3'b000);
        m1_req = 1'b1;
        step();
        m1_req = 1'b0;
        set_cmd(0, 1'b0, 32'h7000, 32'h0, 2'b00, 3'b100);
        m0_req = 1'b1;
        step();
        m0_req = 1'b0;
        #1;
        check_eq("sb_ack1", 32'(m1_rvalid), 32'h1);
        check_eq("sb_rdata1", m1_rdata, 32'h0);
        step();
        #1;
        check_eq("lbu_rvalid0", 32'(m0_rvalid), 32'h1);
        check_eq("lbu_rdata0", m0_rdata, 32'h0000_0055);
        step();

        // lock watchdog: LT locked M1 grants, then M0 gets in
        set_cmd(1, 1'b0, 32'h2010, 32'h0, 2'b00, 3'b010);
        m1_lock = 1'b1; m1_req = 1'b1;
        #1 n1 = int'(m1_gnt);
        step();
        set_cmd(0, 1'b0, 32'h2014, 32'h0, 2'b00, 3'b010);
        m0_req = 1'b1;
        got0 = 1'b0;
        for (int i = 0; i < 12 && !got0; i++) begin
            #1;
            if (m0_gnt) begin
                got0 = 1'b1;
                check_eq("lock_to_flag", 32'(lock_timeout), 32'h1);
            end else if (m1_gnt) begin
                n1++;
            end
            step();
        end
        check_eq("lock_m1_grants", 32'(n1), 32'(LT));
        check_eq("lock_m0_after", 32'(got0), 32'h1);
        m1_lock = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) step();

        // reset while an M0 load is in its access cycle
        set_cmd(0, 1'b0, 32'h2004, 32'h0, 2'b00, 3'b010);
        m0_req = 1'b1;
        step();
        m0_req = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_eq("rmo_rvalid0", 32'(m0_rvalid), 32'h0);
        check_eq("rmo_rdata0", m0_rdata, 32'h0);
        check_eq("rmo_lsu_wren", 32'(lsu_wren), 32'h0);
        check_eq("rmo_lsu_addr", lsu_addr, 32'h0);
        check_eq("rmo_lock_to", 32'(lock_timeout), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            if (!m0_req || last_gnt == 0) begin
                m0_req = ($urandom_range(0, 3) != 0);
                rand_cmd(0);
            end
            if (!m1_req || last_gnt == 1) begin
                m1_req = ($urandom_range(0, 3) != 0);
                rand_cmd(1);
            end
            if ($urandom_range(0, 7) == 0) m1_lock = ~m1_lock;
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
